// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D-cache memory arbiter: FSM state encoding,
// grant identifiers and default port widths.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_I  = 2'd1,
    BUSY_D  = 2'd2,
    RELEASE = 2'd3
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick between the I-cache and D-cache
// requests, favouring whichever side was not granted last.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = req_i | req_d;
    grant_id    = GNT_I;
    if (req_i && req_d) begin
      grant_id = (last_grant == GNT_I) ? GNT_D : GNT_I;
    end else if (req_d) begin
      grant_id = GNT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory port between I-cache and D-cache: grants one
// requester, holds its command until mem_ready, then forces a one-cycle gap.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic              i_mem_ready,
  output logic [DATA_W-1:0] i_mem_rdata,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic              d_mem_ready,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic grant_valid;
  logic grant_id;

  rr_arbiter2 u_rr (
    .req_i       (i_mem_read | i_mem_write),
    .req_d       (d_mem_read | d_mem_write),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      IDLE: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if (grant_valid) begin
          last_grant_d = grant_id;
          // A request with both read and write set is treated as a write.
          if (grant_id == GNT_D) begin
            state_d     = BUSY_D;
            mem_write_d = d_mem_write;
            mem_read_d  = d_mem_read & ~d_mem_write;
            mem_addr_d  = d_mem_addr;
            mem_wdata_d = d_mem_wdata;
          end else begin
            state_d     = BUSY_I;
            mem_write_d = i_mem_write;
            mem_read_d  = i_mem_read & ~i_mem_write;
            mem_addr_d  = i_mem_addr;
            mem_wdata_d = i_mem_wdata;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) begin
          state_d     = RELEASE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          if (state_q == BUSY_I) begin
            i_rdata_d = mem_rdata;
          end else begin
            d_rdata_d = mem_rdata;
          end
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_I;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Ready and read data reach only the granted cache; the other side keeps
  // the last block it was actually given.
  assign i_mem_ready = (state_q == BUSY_I) && mem_ready;
  assign d_mem_ready = (state_q == BUSY_D) && mem_ready;
  assign i_mem_rdata = (state_q == BUSY_I) ? mem_rdata : i_rdata_q;
  assign d_mem_rdata = (state_q == BUSY_D) ? mem_rdata : d_rdata_q;

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: grant latency, round-robin
// ordering, command hold, release spacing, stray ready and reset abort.
module tb_mem_arbiter;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  logic              clk;
  logic              rst_n;
  logic              i_mem_read, i_mem_write;
  logic [ADDR_W-1:0] i_mem_addr;
  logic [DATA_W-1:0] i_mem_wdata;
  logic              i_mem_ready;
  logic [DATA_W-1:0] i_mem_rdata;
  logic              d_mem_read, d_mem_write;
  logic [ADDR_W-1:0] d_mem_addr;
  logic [DATA_W-1:0] d_mem_wdata;
  logic              d_mem_ready;
  logic [DATA_W-1:0] d_mem_rdata;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  int assertions;
  int failures;

  localparam logic [DATA_W-1:0] PAT_A5 = {16{8'hA5}};
  localparam logic [DATA_W-1:0] PAT_55 = {16{8'h55}};
  localparam logic [DATA_W-1:0] PAT_77 = {16{8'h77}};
  localparam logic [DATA_W-1:0] PAT_D1 = {8{16'h1111}};

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_mem_read  (i_mem_read),
    .i_mem_write (i_mem_write),
    .i_mem_addr  (i_mem_addr),
    .i_mem_wdata (i_mem_wdata),
    .i_mem_ready (i_mem_ready),
    .i_mem_rdata (i_mem_rdata),
    .d_mem_read  (d_mem_read),
    .d_mem_write (d_mem_write),
    .d_mem_addr  (d_mem_addr),
    .d_mem_wdata (d_mem_wdata),
    .d_mem_ready (d_mem_ready),
    .d_mem_rdata (d_mem_rdata),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] got,
                             input logic [DATA_W-1:0] exp);
    assertions++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic [ADDR_W-1:0] ia,
                               input logic dr, input logic dw,
                               input logic [ADDR_W-1:0] da);
    i_mem_read  = ir;
    i_mem_write = 1'b0;
    i_mem_addr  = ia;
    d_mem_read  = dr;
    d_mem_write = dw;
    d_mem_addr  = da;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DATA_W-1:0] last_i, last_d, rd;
  logic              exp_d;

  initial begin
    assertions = 0;
    failures   = 0;
    rst_n      = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
    i_mem_wdata = '0;
    d_mem_wdata = '0;
    mem_ready   = 1'b0;
    mem_rdata   = '0;
    tick();
    tick();

    checkOutput("rst_mem_read",  mem_read,    0);
    checkOutput("rst_mem_write", mem_write,   0);
    checkOutput("rst_mem_addr",  mem_addr,    0);
    checkOutput("rst_mem_wdata", mem_wdata,   0);
    checkOutput("rst_i_ready",   i_mem_ready, 0);
    checkOutput("rst_d_ready",   d_mem_ready, 0);
    rst_n = 1'b1;
    tick();

    // I-only read: command one cycle later, ready/data forwarded same cycle
    applyStimulus(1'b1, 28'h0000010, 1'b0, 1'b0, '0);
    tick();
    checkOutput("t1_mem_read",  mem_read,    1);
    checkOutput("t1_mem_write", mem_write,   0);
    checkOutput("t1_mem_addr",  mem_addr,    28'h0000010);
    checkOutput("t1_i_ready_0", i_mem_ready, 0);
    mem_ready = 1'b1;
    mem_rdata = PAT_A5;
    i_mem_read = 1'b0;
    #1;
    checkOutput("t1_i_ready",  i_mem_ready, 1);
    checkOutput("t1_i_rdata",  i_mem_rdata, PAT_A5);
    checkOutput("t1_d_ready",  d_mem_ready, 0);
    checkOutput("t1_d_rdata",  d_mem_rdata, 0);
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    #1;
    checkOutput("t1_rel_read",   mem_read,    0);
    checkOutput("t1_rel_iready", i_mem_ready, 0);
    checkOutput("t1_i_hold",     i_mem_rdata, PAT_A5);
    tick();

    // Stray mem_ready while idle
    mem_ready = 1'b1;
    mem_rdata = PAT_55;
    #1;
    checkOutput("t2_i_ready", i_mem_ready, 0);
    checkOutput("t2_d_ready", d_mem_ready, 0);
    checkOutput("t2_d_rdata", d_mem_rdata, 0);
    checkOutput("t2_i_rdata", i_mem_rdata, PAT_A5);
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    #1;
    checkOutput("t2_mem_read",  mem_read,  0);
    checkOutput("t2_mem_write", mem_write, 0);

    // Simultaneous I read / D write: D wins, address held, I 3 cycles later
    applyStimulus(1'b1, 28'h0000020, 1'b0, 1'b1, 28'h0000001);
    d_mem_wdata = PAT_D1;
    tick();
    checkOutput("t3_mem_write", mem_write, 1);
    checkOutput("t3_mem_read",  mem_read,  0);
    checkOutput("t3_mem_addr",  mem_addr,  28'h0000001);
    checkOutput("t3_mem_wdata", mem_wdata, PAT_D1);
    d_mem_addr = 28'h0000002;
    tick();
    checkOutput("t3_addr_held", mem_addr,  28'h0000001);
    mem_ready = 1'b1;
    #1;
    checkOutput("t3_d_ready", d_mem_ready, 1);
    checkOutput("t3_i_ready", i_mem_ready, 0);
    d_mem_write = 1'b0;
    tick();
    mem_ready = 1'b0;
    #1;
    checkOutput("t3_n1_read",  mem_read,  0);
    checkOutput("t3_n1_write", mem_write, 0);
    tick();
    checkOutput("t3_n2_read",  mem_read,  0);
    tick();
    checkOutput("t3_n3_read",  mem_read,  1);
    checkOutput("t3_n3_addr",  mem_addr,  28'h0000020);
    mem_ready = 1'b1;
    mem_rdata = PAT_77;
    i_mem_read = 1'b0;
    #1;
    checkOutput("t3_i_ready2", i_mem_ready, 1);
    checkOutput("t3_i_rdata2", i_mem_rdata, PAT_77);
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    tick();

    // Continuous contention: grants alternate D, I, D, I
    last_i = PAT_77;
    last_d = PAT_55 ^ PAT_55;
    applyStimulus(1'b1, 28'h0000100, 1'b1, 1'b0, 28'h0000200);
    for (int k = 0; k < 4; k++) begin
      exp_d = (k % 2 == 0);
      tick();
      checkOutput($sformatf("t4_addr_%0d", k), mem_addr,
                  exp_d ? 28'h0000200 : 28'h0000100);
      checkOutput($sformatf("t4_read_%0d", k), mem_read, 1);
      rd = DATA_W'(k + 1) << 8;
      mem_ready = 1'b1;
      mem_rdata = rd;
      #1;
      checkOutput($sformatf("t4_dready_%0d", k), d_mem_ready, exp_d);
      checkOutput($sformatf("t4_iready_%0d", k), i_mem_ready, !exp_d);
      if (exp_d) begin
        checkOutput($sformatf("t4_ihold_%0d", k), i_mem_rdata, last_i);
        last_d = rd;
      end else begin
        checkOutput($sformatf("t4_dhold_%0d", k), d_mem_rdata, last_d);
        last_i = rd;
      end
      tick();
      mem_ready = 1'b0;
      mem_rdata = '0;
      tick();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
    tick();

    // Read and write both set: issued as a write
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 28'h0000003);
    tick();
    checkOutput("t5_mem_write", mem_write, 1);
    checkOutput("t5_mem_read",  mem_read,  0);
    checkOutput("t5_mem_addr",  mem_addr,  28'h0000003);
    mem_ready = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
    tick();
    mem_ready = 1'b0;
    tick();

    // Reset during BUSY_I aborts the transaction without a ready pulse
    applyStimulus(1'b1, 28'h0000030, 1'b0, 1'b0, '0);
    tick();
    checkOutput("t6_busy_read", mem_read, 1);
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
    tick();
    checkOutput("t6_rst_read",   mem_read,    0);
    checkOutput("t6_rst_addr",   mem_addr,    0);
    checkOutput("t6_rst_iready", i_mem_ready, 0);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = PAT_A5;
    #1;
    checkOutput("t6_late_iready", i_mem_ready, 0);
    checkOutput("t6_late_dready", d_mem_ready, 0);
    checkOutput("t6_i_rdata",     i_mem_rdata, 0);
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    applyStimulus(1'b1, 28'h0000040, 1'b1, 1'b0, 28'h0000050);
    tick();
    checkOutput("t6_tie_addr", mem_addr, 28'h0000050);
    checkOutput("t6_tie_read", mem_read, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertions, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single off-chip memory port between the I-cache miss/refill interface and the D-cache miss/write-back interface of the pipelined MIPS core.
- Sits between the two caches and the slow memory model.
- Grants one requester at a time, registers and holds its command on the memory port until memory returns ready, then routes the ready/read data back to the granted cache.
- Round-robin on simultaneous requests, so neither cache starves.

Parameters:
ADDR_W, 28, memory block address width (word address [29:2] of a 4-word block)
DATA_W, 128, memory block data width

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
i_mem_read  in  1  I-cache block read request
i_mem_write  in  1  I-cache block write request (tied 0 by I-cache, still arbitrated)
i_mem_addr  in  ADDR_W  I-cache block address
i_mem_wdata  in  DATA_W  I-cache write data
i_mem_ready  out  1  completion pulse to I-cache
i_mem_rdata  out  DATA_W  read data to I-cache
d_mem_read  in  1  D-cache block read request
d_mem_write  in  1  D-cache block write-back request
d_mem_addr  in  ADDR_W  D-cache block address
d_mem_wdata  in  DATA_W  D-cache write data
d_mem_ready  out  1  completion pulse to D-cache
d_mem_rdata  out  DATA_W  read data to D-cache
mem_read  out  1  memory read command
mem_write  out  1  memory write command
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ready  in  1  memory completion (one cycle)
mem_rdata  in  DATA_W  memory read data, valid with mem_ready

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- States are IDLE, BUSY_I, BUSY_D and RELEASE. Reset state is IDLE.
- Reset values:
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - last_grant=I, so the first tie goes to D.
  - i/d_mem_ready=0.
- Request definition: req_x = x_mem_read | x_mem_write.
  - If both bits are high, the request is a write: mem_write=1, mem_read=0.
- IDLE:
  - If only one req is high, grant that requester.
  - If both are high, grant the requester that is not last_grant.
  - On grant, register the latched addr, wdata and rd/wr onto the mem_* outputs. The command therefore appears on the memory port the cycle after the request is first seen (1-cycle grant latency).
  - Update last_grant.
  - Go to BUSY_I or BUSY_D.
  - If neither req is high, stay in IDLE with outputs 0.
- BUSY_x:
  - mem_* outputs are held constant from the latched copy; requester input changes are ignored.
  - x_mem_ready = mem_ready, combinational, in the same cycle. The other side's ready is always 0.
  - x_mem_rdata = mem_rdata, forwarded combinationally while granted. Otherwise x_mem_rdata is held at the last value delivered to x (registered copy), never at the other side's data.
  - On mem_ready, go to RELEASE.
- RELEASE:
  - Lasts exactly 1 cycle: mem_read=mem_write=0, no grant, both readies 0.
  - This guarantees the finishing cache has dropped its request before re-arbitration.
  - Then go to IDLE.
  - Minimum back-to-back spacing: mem_ready at cycle n, next mem command at n+3 (RELEASE at n+1, IDLE at n+2, command registered at n+3).
- mem_ready outside BUSY_x is ignored and produces no ready pulse.
- A request that drops while in BUSY_x does not abort the transaction. Memory completes; the pulse is still emitted.
- Reset mid-transaction: in the next cycle the block returns to IDLE with all outputs 0. The pending transaction is discarded; the caches reset simultaneously.
- Width rules: addr and data pass through unmodified, with no arithmetic.

Decomposition:
- A shared package holds the state encoding (2-bit: IDLE=0, BUSY_I=1, BUSY_D=2, RELEASE=3) and the grant IDs (GNT_I=0, GNT_D=1).
- One natural sub-module, rr_arbiter2: a combinational 2-way round-robin pick from req_i, req_d and last_grant. The FSM, latches and ready routing stay in mem_arbiter.

Test Plan:
- Reset then I-only read at addr 0x0000010:
  - mem_read=1 and mem_addr=0x0000010 one cycle later.
  - After mem_ready with mem_rdata=0xA5..A5, i_mem_ready=1 the same cycle and i_mem_rdata=0xA5..A5.
  - d_mem_ready stays 0.
- Simultaneous I read and D write after reset:
  - D is granted first (mem_write=1 with D's addr/wdata).
  - After completion, RELEASE (1 cycle), then I is granted. Its command appears exactly 3 cycles after the D mem_ready.
- Back-to-back contention over 4 transactions (both requesters continuously requesting) -> grants alternate D, I, D, I.
- D changes d_mem_addr from 0x1 to 0x2 mid-BUSY_D -> mem_addr stays 0x1 until completion.
- Stray mem_ready pulse in IDLE -> no ready pulse on either side, and the state stays IDLE.
- rst_n=0 asserted during BUSY_I -> next cycle: IDLE, mem_read=0, and no ready pulse ever issued for the aborted request.
